// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from several requesters.
// Each requester owns a one-word holding slot; one word is in flight at a time.
module uart_tx_arbiter #(
   parameter int unsigned P_REQUESTERS = 4,
   parameter int unsigned P_DATA_WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   resetn,
   input  logic [P_REQUESTERS*P_DATA_WIDTH-1:0]   ip_req_data,
   input  logic [P_REQUESTERS-1:0]                i_req_dv,
   output logic [P_REQUESTERS-1:0]                o_req_full,
   output logic [P_REQUESTERS-1:0]                o_req_done,
   output logic [P_REQUESTERS-1:0]                o_overflow,
   output logic [P_DATA_WIDTH-1:0]                op_tx_data,
   output logic                                   o_tx_dv,
   input  logic                                   i_tx_ready,
   output logic [$clog2(P_REQUESTERS)-1:0]        o_grant_id,
   output logic                                   o_busy
);

   localparam int unsigned ID_W = $clog2(P_REQUESTERS);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_LOW  = 2'd2,
      WAIT_HIGH = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [1:0]              to_cnt_q, to_cnt_d;
   logic [P_REQUESTERS-1:0] full_q, full_d;
   logic [P_REQUESTERS-1:0] done_q, done_d;
   logic [P_REQUESTERS-1:0] ovf_q, ovf_d;
   logic [P_DATA_WIDTH-1:0] slot_q [P_REQUESTERS];
   logic [P_DATA_WIDTH-1:0] slot_d [P_REQUESTERS];
   logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [ID_W-1:0]         grant_q, grant_d;
   logic [ID_W-1:0]         last_q, last_d;
   logic [ID_W-1:0]         pick_s;
   logic                    tx_dv_q, tx_dv_d;
   logic                    busy_q, busy_d;

   // First full slot found searching upward from the requester after the last grant.
   function automatic logic [ID_W-1:0] rr_pick(input logic [P_REQUESTERS-1:0] full,
                                                input logic [ID_W-1:0]         last);
      logic [ID_W-1:0] cand;
      logic [ID_W-1:0] pick;
      logic            found;
      pick  = last;
      found = 1'b0;
      for (int unsigned i = 1; i <= P_REQUESTERS; i++) begin
         cand = ID_W'((32'(last) + i) % P_REQUESTERS);
         if (!found && full[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign pick_s = rr_pick(full_q, last_q);

   // FSM state and WAIT_LOW timeout counter.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         to_cnt_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Next-state logic; ready stuck high for four WAIT_LOW cycles counts as the low phase.
   always_comb begin
      state_d  = state_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
         IDLE: begin
            if ((|full_q) && i_tx_ready) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d  = WAIT_LOW;
            to_cnt_d = 2'd0;
         end
         WAIT_LOW: begin
            if (!i_tx_ready || (to_cnt_q == 2'd3)) begin
               state_d = WAIT_HIGH;
            end else begin
               to_cnt_d = to_cnt_q + 2'd1;
            end
         end
         WAIT_HIGH: begin
            if (i_tx_ready) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT_HIGH;
            end
         end
         default: begin
            state_d  = IDLE;
            to_cnt_d = 2'd0;
         end
      endcase
   end

   // Output and grant bookkeeping, registered from the next state.
   always_comb begin
      grant_d   = grant_q;
      tx_data_d = tx_data_q;
      last_d    = last_q;
      done_d    = '0;
      tx_dv_d   = (state_d == ISSUE);
      busy_d    = (state_d != IDLE);
      if ((state_q == IDLE) && (state_d == ISSUE)) begin
         grant_d   = pick_s;
         tx_data_d = slot_q[pick_s];
      end else begin
         grant_d   = grant_q;
      end
      if ((state_q == WAIT_HIGH) && i_tx_ready) begin
         done_d[grant_q] = 1'b1;
         last_d          = grant_q;
      end else begin
         last_d          = last_q;
      end
   end

   // Holding slots: the issued slot frees in the ISSUE cycle, so a same-cycle dv refills it.
   always_comb begin
      full_d = full_q;
      ovf_d  = '0;
      for (int n = 0; n < P_REQUESTERS; n++) begin
         slot_d[n] = slot_q[n];
         if ((state_q == ISSUE) && (grant_q == ID_W'(n))) begin
            full_d[n] = 1'b0;
         end else begin
            full_d[n] = full_q[n];
         end
         if (i_req_dv[n] && !full_d[n]) begin
            full_d[n] = 1'b1;
            slot_d[n] = ip_req_data[n*P_DATA_WIDTH +: P_DATA_WIDTH];
         end else begin
            ovf_d[n]  = i_req_dv[n];
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         full_q    <= '0;
         done_q    <= '0;
         ovf_q     <= '0;
         tx_data_q <= '0;
         grant_q   <= '0;
         last_q    <= ID_W'(P_REQUESTERS - 1);
         tx_dv_q   <= 1'b0;
         busy_q    <= 1'b0;
         for (int n = 0; n < P_REQUESTERS; n++) begin
            slot_q[n] <= '0;
         end
      end else begin
         full_q    <= full_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         tx_dv_q   <= tx_dv_d;
         busy_q    <= busy_d;
         for (int n = 0; n < P_REQUESTERS; n++) begin
            slot_q[n] <= slot_d[n];
         end
      end
   end

   assign o_req_full = full_q;
   assign o_req_done = done_q;
   assign o_overflow = ovf_q;
   assign op_tx_data = tx_data_q;
   assign o_tx_dv    = tx_dv_q;
   assign o_grant_id = grant_q;
   assign o_busy     = busy_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter P_REQUESTERS, default 4, number of requester ports (2..8).
REQ-002 Parameter P_DATA_WIDTH, default 32, width of one transfer word; equals uart_tx ip_data width.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 ip_req_data  input  P_REQUESTERS*P_DATA_WIDTH  requester n data in slice [n*W +: W].
REQ-006 i_req_dv  input  P_REQUESTERS  per-requester one-cycle data-valid pulse.
REQ-007 o_req_full  output  P_REQUESTERS  holding slot n occupied.
REQ-008 o_req_done  output  P_REQUESTERS  one-cycle pulse: word from requester n fully transmitted.
REQ-009 o_overflow  output  P_REQUESTERS  one-cycle pulse: dv on a full slot, word dropped.
REQ-010 op_tx_data  output  P_DATA_WIDTH  word to uart_tx ip_data.
REQ-011 o_tx_dv  output  1  to uart_tx i_dv; one-cycle pulse.
REQ-012 i_tx_ready  input  1  from uart_tx o_ready.
REQ-013 o_grant_id  output  clog2(P_REQUESTERS)  index of requester owning the link.
REQ-014 o_busy  output  1  high in any state other than IDLE.

Function
REQ-015 Each requester has one holding slot; i_req_dv[n]=1 with slot n empty latches ip_req_data slice n and sets o_req_full[n] on the next edge.
REQ-016 i_req_dv[n]=1 with slot n full drops the word, leaves the slot unchanged, and pulses o_overflow[n] the next cycle.
REQ-017 Slot n clears on the cycle its word is issued (o_tx_dv=1); i_req_dv[n] in that same cycle is accepted, not an overflow.
REQ-018 FSM states: IDLE, ISSUE, WAIT_LOW, WAIT_HIGH.
REQ-019 IDLE: if any slot full and i_tx_ready=1, select winner by round-robin, register o_grant_id and op_tx_data, and go to ISSUE.
REQ-020 Round-robin search starts at (last_grant+1) mod P_REQUESTERS; last_grant resets to P_REQUESTERS-1, so requester 0 wins first.
REQ-021 ISSUE: assert o_tx_dv for exactly one cycle, clear the winner slot, and go to WAIT_LOW.
REQ-022 WAIT_LOW: wait for i_tx_ready=0, then go to WAIT_HIGH.
REQ-023 WAIT_LOW timeout: if i_tx_ready stays 1 for 4 cycles, treat it as dropped low and go to WAIT_HIGH.
REQ-024 WAIT_HIGH: on i_tx_ready=1, pulse o_req_done[o_grant_id] one cycle, update last_grant, and return to IDLE.
REQ-025 Minimum spacing between o_tx_dv pulses is 4 cycles; no requester is granted twice while another slot was full at the preceding IDLE decision.
REQ-026 op_tx_data and o_grant_id hold stable from ISSUE until the next IDLE grant.
REQ-027 At most one bit of o_req_done is set in any cycle.
REQ-028 Requests arriving while busy are buffered in their slot and arbitrated at the next IDLE.

Reset
REQ-029 resetn=0 asynchronously forces:
- FSM to IDLE.
- All slots empty.
- o_req_full, o_req_done, o_overflow, o_tx_dv, o_busy to 0.
- op_tx_data to 0, o_grant_id to 0, last_grant to P_REQUESTERS-1.
REQ-030 Reset mid-transfer discards the in-flight grant and all slots with no done pulse.
REQ-031 Operation resumes from the first edge after resetn rises.

Verification
REQ-032 Single word: after reset, requester 2 pulses dv with 0xDEADBEEF -> o_tx_dv pulses once with op_tx_data=0xDEADBEEF and o_grant_id=2; the uart_rx loopback receives 0xDEADBEEF; o_req_done[2] pulses once.
REQ-033 Fairness: all 4 requesters pulse dv in the same cycle with 0x0..0x3 -> issue order 0,1,2,3; each receives one done pulse; loopback sees the words in that order.
REQ-034 Overflow: requester 1 pulses dv twice while its slot is full (second word 0x55) -> o_overflow[1] pulses once; 0x55 is never transmitted; the first word is delivered.
REQ-035 Round-robin wrap: requesters 3 and 0 both full after a grant to requester 3 -> requester 0 is granted next, then 3.
REQ-036 Reset mid-operation: resetn low during WAIT_HIGH with slots 1 and 2 full -> all outputs 0 at once; after release, no done or tx_dv pulses until new dv.
REQ-037 Stuck ready: i_tx_ready held 1 after issue -> WAIT_HIGH is reached within 4 cycles, and the done pulse follows.
